// File: rtl/pesanteur_pkg.sv
// pesanteur_pkg
//   Shared definitions for the gravity engine.
//   - state_t       : engine state encoding
//   - LFSR_SEED/TAPS: colour LFSR seed and feedback taps (x^5 + x^3 + 1)
//   - col_height()  : pulls the height field of one column out of the packed
//                     height bus (bus zero-extended to HBUS_W by the caller)
package pesanteur_pkg;

    typedef enum logic [2:0] {
        SPAWN  = 3'd0,
        FALL   = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        LOST   = 3'd4
    } state_t;

    localparam logic [4:0] LFSR_SEED = 5'b00001;
    // Fibonacci form, shift toward MSB, feedback = q[4] ^ q[2].
    localparam logic [4:0] LFSR_TAPS = 5'b10100;

    // Wide enough for 8 columns of up to 8-bit height fields.
    localparam int HBUS_W = 64;

    function automatic logic [7:0] col_height(input logic [HBUS_W-1:0] bus,
                                              input int               c,
                                              input int               hw);
        logic [HBUS_W-1:0] sh;
        sh = bus >> (c * hw);
        return sh[7:0] & 8'((1 << hw) - 1);
    endfunction

endpackage

// File: rtl/pesanteur_n_lfsr.sv
// lfsr_couleur
//   Free-running W-bit Fibonacci LFSR used to pick brick colours.
//   Starting from a non-zero seed it never reaches the all-zero state.
//   Ports:
//     clk    in   system clock
//     reset  in   synchronous, active-low reset (loads SEED)
//     en     in   advance enable
//     q      out  current LFSR value
module lfsr_couleur #(
    parameter int           W    = 5,
    parameter logic [W-1:0] SEED = W'(1),
    parameter logic [W-1:0] TAPS = W'(20)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] q
);

    logic fb;

    assign fb = ^(q & TAPS);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[W-2:0], fb};
        end
    end

endmodule

// File: rtl/pesanteur_n.sv
// pesanteur_n
//   Gravity engine for the falling-brick game. Moves one brick down a set of
//   NCOLS column stacks on each gravity tick, accepts player column moves,
//   requests stack increments on landing, requests bottom-row removal when
//   every column is non-empty, and flags game loss when the spawn column is
//   full.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   SPAWN  | place a new brick at the top of the middle column, or lose
//   FALL   | brick active; ticks move it down, col_req moves it sideways
//   SETTLE | one idle cycle so the external counters absorb plus/aligne
//   CHECK  | clear a full bottom row (then re-settle) or spawn next brick
//   LOST   | sticky game-over, only reset leaves it
//
//   Ports:
//     clk      in   system clock
//     reset    in   synchronous, active-low reset
//     hauteur  in   packed column heights, column i at [i*HW +: HW]
//     col_req  in   player-requested column
//     pulse    in   gravity tick level, rising edge used
//     plus     out  one-hot one-cycle increment to the landing column
//     aligne   out  one-cycle request to drop the bottom row everywhere
//     perdu    out  sticky game-lost flag
//     row      out  brick cell index, 0 = bottom
//     col_cur  out  brick column
//     couleur  out  brick colour, 0 when no brick is active
//     active   out  brick is falling
module pesanteur_n
    import pesanteur_pkg::*;
#(
    parameter  int NCOLS  = 3,
    parameter  int HEIGHT = 7,
    parameter  int CLRW   = 5,
    localparam int HW     = $clog2(HEIGHT + 1),
    localparam int CW     = $clog2(NCOLS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCOLS*HW-1:0] hauteur,
    input  logic [CW-1:0]       col_req,
    input  logic                pulse,
    output logic [NCOLS-1:0]    plus,
    output logic                aligne,
    output logic                perdu,
    output logic [HW-1:0]       row,
    output logic [CW-1:0]       col_cur,
    output logic [CLRW-1:0]     couleur,
    output logic                active
);

    localparam logic [CW-1:0] COL_MID = CW'(NCOLS / 2);
    localparam logic [HW-1:0] ROW_TOP = HW'(HEIGHT - 1);
    localparam logic [HW-1:0] H_FULL  = HW'(HEIGHT);

    state_t            state, state_n;
    logic [HW-1:0]     row_n;
    logic [CW-1:0]     col_n;
    logic [CLRW-1:0]   couleur_n;
    logic              active_n;
    logic [NCOLS-1:0]  plus_n;
    logic              aligne_n;
    logic              perdu_n;
    logic              pulse_q;
    logic              tick;
    logic [CLRW-1:0]   lfsr_q;
    logic [HBUS_W-1:0] hbus;
    logic [HW-1:0]     h_cur, h_req, h_mid;
    logic              req_ok;
    logic              all_filled;

    lfsr_couleur #(
        .W    (CLRW),
        .SEED (CLRW'(LFSR_SEED)),
        .TAPS (CLRW'(LFSR_TAPS))
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .q     (lfsr_q)
    );

    assign tick   = pulse & ~pulse_q;
    assign hbus   = HBUS_W'(hauteur);
    assign h_cur  = HW'(col_height(hbus, int'(col_cur), HW));
    assign h_req  = HW'(col_height(hbus, int'(col_req), HW));
    assign h_mid  = HW'(col_height(hbus, int'(COL_MID), HW));
    assign req_ok = int'(col_req) < NCOLS;

    always_comb begin
        all_filled = 1'b1;
        for (int c = 0; c < NCOLS; c++) begin
            if (col_height(hbus, c, HW) == 8'd0) begin
                all_filled = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= SPAWN;
            row     <= ROW_TOP;
            col_cur <= COL_MID;
            couleur <= '0;
            active  <= 1'b0;
            plus    <= '0;
            aligne  <= 1'b0;
            perdu   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state   <= state_n;
            row     <= row_n;
            col_cur <= col_n;
            couleur <= couleur_n;
            active  <= active_n;
            plus    <= plus_n;
            aligne  <= aligne_n;
            perdu   <= perdu_n;
            pulse_q <= pulse;
        end
    end

    always_comb begin
        state_n   = state;
        row_n     = row;
        col_n     = col_cur;
        couleur_n = couleur;
        active_n  = active;
        plus_n    = '0;
        aligne_n  = 1'b0;
        perdu_n   = perdu;
        unique case (state)
            SPAWN: begin
                row_n = ROW_TOP;
                col_n = COL_MID;
                if (h_mid >= H_FULL) begin
                    perdu_n  = 1'b1;
                    active_n = 1'b0;
                    state_n  = LOST;
                end else begin
                    couleur_n = lfsr_q;
                    active_n  = 1'b1;
                    state_n   = FALL;
                end
            end
            FALL: begin
                if (tick) begin
                    // Moves are ignored on tick cycles so landing always
                    // uses the column the brick actually fell in.
                    if (row == h_cur) begin
                        plus_n    = NCOLS'(1) << col_cur;
                        active_n  = 1'b0;
                        couleur_n = '0;
                        state_n   = SETTLE;
                    end else begin
                        row_n = row - HW'(1);
                    end
                end else if (col_req != col_cur && req_ok && h_req <= row) begin
                    col_n = col_req;
                end
            end
            SETTLE: begin
                state_n = CHECK;
            end
            CHECK: begin
                // Going back through SETTLE lets a second full row be seen.
                if (all_filled) begin
                    aligne_n = 1'b1;
                    state_n  = SETTLE;
                end else begin
                    state_n = SPAWN;
                end
            end
            LOST: begin
                perdu_n   = 1'b1;
                active_n  = 1'b0;
                couleur_n = '0;
            end
            default: begin
                state_n = SPAWN;
            end
        endcase
    end

endmodule

// File: tb/tb_pesanteur_n.sv
module tb_pesanteur_n;

    localparam int NCOLS  = 3;
    localparam int HEIGHT = 7;
    localparam int HW     = 3;
    localparam int CW     = 2;
    localparam int CLRW   = 5;

    typedef struct {
        int kind;   // 0 = row after tick, 1 = plus on landing
        int val;
    } exp_t;

    logic                clk     = 1'b0;
    logic                reset   = 1'b0;
    logic                pulse   = 1'b0;
    logic [CW-1:0]       col_req = 2'd1;
    logic [NCOLS*HW-1:0] hauteur;
    logic [NCOLS-1:0]    plus;
    logic                aligne;
    logic                perdu;
    logic [HW-1:0]       row;
    logic [CW-1:0]       col_cur;
    logic [CLRW-1:0]     couleur;
    logic                active;

    logic [HW-1:0] h [NCOLS];
    exp_t          sb_q [$];

    int checks  = 0;
    int errors  = 0;
    int n_plus  = 0;
    int n_align = 0;
    int n_both  = 0;
    int m_row   = 6;
    int m_col   = 1;

    assign hauteur = {h[2], h[1], h[0]};

    pesanteur_n dut (
        .clk     (clk),
        .reset   (reset),
        .hauteur (hauteur),
        .col_req (col_req),
        .pulse   (pulse),
        .plus    (plus),
        .aligne  (aligne),
        .perdu   (perdu),
        .row     (row),
        .col_cur (col_cur),
        .couleur (couleur),
        .active  (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; the bench plays the external column counters, applying the
    // plus/aligne that were asserted before this edge.
    task automatic step();
        logic [NCOLS-1:0] p;
        logic             a;
        p = plus;
        a = aligne;
        @(posedge clk);
        #1;
        for (int i = 0; i < NCOLS; i++) begin
            if (p[i]) h[i] = h[i] + 3'd1;
        end
        if (a) begin
            for (int i = 0; i < NCOLS; i++) begin
                if (h[i] != 3'd0) h[i] = h[i] - 3'd1;
            end
        end
        if (plus != '0) n_plus++;
        if (aligne) n_align++;
        if (plus != '0 && aligne) n_both++;
    endtask

    task automatic tick(input logic [CW-1:0] req, output bit landed);
        exp_t e;
        landed = (m_row == int'(h[m_col]));
        e.kind = landed ? 1 : 0;
        e.val  = landed ? (1 << m_col) : (m_row - 1);
        sb_q.push_back(e);
        col_req = req;
        pulse   = 1'b1;
        step();
        e = sb_q.pop_front();
        if (e.kind == 1) begin
            chk("land_plus", int'(plus), e.val);
            chk("land_active", int'(active), 0);
        end else begin
            chk("tick_row", int'(row), e.val);
        end
        chk("tick_col_hold", int'(col_cur), m_col);
        if (!landed) m_row--;
        col_req = CW'(m_col);
        pulse   = 1'b0;
        step();
    endtask

    task automatic wait_active(input int budget, output int n);
        n = 0;
        while (!active && n < budget) begin
            step();
            n++;
        end
        chk("wait_active", int'(active), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit landed;
        int n, p0, a0, k;
        exp_t e;

        // ---- reset ----
        h[0] = 3'd1; h[1] = 3'd2; h[2] = 3'd1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse = ~pulse;
            step();
        end
        pulse = 1'b0;
        chk("rst_plus", int'(plus), 0);
        chk("rst_aligne", int'(aligne), 0);
        chk("rst_perdu", int'(perdu), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_couleur", int'(couleur), 0);
        chk("rst_row", int'(row), 6);
        chk("rst_col", int'(col_cur), 1);
        reset = 1'b1;
        wait_active(2, n);
        chk("spawn_row", int'(row), 6);
        chk("spawn_col", int'(col_cur), 1);
        chk("spawn_couleur_nz", int'(couleur != '0), 1);
        m_row = 6; m_col = 1;

        // ---- free fall onto {1,2,1}, then the landing fills the bottom row ----
        p0 = n_plus;
        for (int i = 0; i < 5; i++) tick(2'd1, landed);
        chk("ff_plus_cycles", n_plus - p0, 1);
        chk("ff_couleur_off", int'(couleur), 0);
        a0 = n_align;
        wait_active(10, n);
        chk("ff_aligne_cycles", n_align - a0, 1);
        chk("ff_h0", int'(h[0]), 0);
        chk("ff_h1", int'(h[1]), 2);
        chk("ff_h2", int'(h[2]), 0);
        m_row = 6; m_col = 1;

        // ---- moves: bring brick to row 4, then column 1 grows to 5 ----
        tick(2'd1, landed);
        tick(2'd1, landed);
        h[1] = 3'd5;
        col_req = 2'd0; step();
        chk("mv_to0", int'(col_cur), 0);
        m_col = 0;
        col_req = 2'd1; step();
        chk("mv_blocked", int'(col_cur), 0);
        col_req = 2'd3; step();
        chk("mv_out_of_range", int'(col_cur), 0);
        col_req = 2'd2; step();
        chk("mv_jump2", int'(col_cur), 2);
        col_req = 2'd0; step();
        chk("mv_back0", int'(col_cur), 0);
        tick(2'd2, landed);
        chk("mv_tick_row", int'(row), 3);
        k = 0;
        landed = 1'b0;
        while (!landed && k < 6) begin
            tick(2'd0, landed);
            k++;
        end
        wait_active(6, n);
        chk("land_to_active", 2 + n, 4);
        chk("mv_h0", int'(h[0]), 1);
        m_row = 6; m_col = 1;

        // ---- line clear: {1,0,1}, brick lands in column 1 ----
        h[0] = 3'd1; h[1] = 3'd0; h[2] = 3'd1;
        k = 0;
        landed = 1'b0;
        while (!landed && k < 10) begin
            tick(2'd1, landed);
            k++;
        end
        a0 = n_align;
        pulse = 1'b1;            // arrives in CHECK, must be dropped
        step();
        chk("clr_aligne_on", int'(aligne), 1);
        pulse = 1'b0;
        step();
        chk("clr_aligne_off", int'(aligne), 0);
        wait_active(6, n);
        chk("clr_aligne_cycles", n_align - a0, 1);
        chk("clr_heights", int'(h[0]) + int'(h[1]) + int'(h[2]), 0);
        chk("clr_row", int'(row), 6);
        m_row = 6; m_col = 1;

        // ---- pulse held high: exactly one decrement ----
        e.kind = 0; e.val = m_row - 1;
        sb_q.push_back(e);
        pulse = 1'b1;
        step();
        e = sb_q.pop_front();
        chk("hold_first", int'(row), e.val);
        for (int i = 0; i < 9; i++) step();
        chk("hold_row", int'(row), 5);
        pulse = 1'b0;
        step();
        m_row = 5;

        // ---- loss ----
        h[1] = 3'd4;
        tick(2'd1, landed);
        tick(2'd1, landed);
        h[1] = 3'd7;
        k = 0;
        while (!perdu && k < 8) begin
            step();
            k++;
        end
        chk("lost_perdu", int'(perdu), 1);
        chk("lost_active", int'(active), 0);
        chk("lost_couleur", int'(couleur), 0);
        p0 = n_plus;
        col_req = 2'd0;
        for (int i = 0; i < 6; i++) begin
            pulse = ~pulse;
            step();
        end
        pulse = 1'b0;
        chk("lost_sticky", int'(perdu), 1);
        chk("lost_still_idle", int'(active), 0);
        chk("lost_row", int'(row), 6);
        chk("lost_col", int'(col_cur), 1);
        chk("lost_no_plus", n_plus - p0, 0);
        reset = 1'b0;
        step();
        chk("lost_reset_perdu", int'(perdu), 0);
        h[1] = 3'd0;
        col_req = 2'd1;
        reset = 1'b1;
        wait_active(3, n);
        chk("respawn_perdu", int'(perdu), 0);

        chk("excl_plus_aligne", n_both, 0);
        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
